// File: rtl/seq_divider_if.sv
// Operand/result bundle between a controlling FSM (master) and seq_divider (slave).
interface seq_divider_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, DW steps per operation,
// single-cycle divide-by-zero path with saturated quotient and dz flag.
module seq_divider #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8,
  parameter int unsigned CW = 5
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [VW-1:0] rem_r;
  logic [DW-1:0] q_r;
  logic [VW-1:0] dvs_r;
  logic [DW-1:0] quotient_r;
  logic [VW-1:0] remainder_r;
  logic          dz_r;

  logic [VW:0]   shifted_c;
  logic          ge_c;
  logic [VW-1:0] rem_next_c;
  logic [DW-1:0] q_next_c;

  // One restoring step. The partial remainder stays below the divisor, so after a
  // successful subtract the difference fits in VW bits and the modulo result is exact.
  always_comb begin
    shifted_c  = {rem_r, q_r[DW-1]};
    ge_c       = (shifted_c >= {1'b0, dvs_r});
    rem_next_c = ge_c ? (shifted_c[VW-1:0] - dvs_r) : shifted_c[VW-1:0];
    q_next_c   = {q_r[DW-2:0], ge_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dz_r        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            dvs_r <= bus.divisor;
            q_r   <= bus.dividend;
            rem_r <= '0;
            if (bus.divisor == '0) begin
              state       <= S_DONE;
              cnt         <= '0;
              quotient_r  <= '1;
              remainder_r <= '0;
              dz_r        <= 1'b1;
            end else begin
              state <= S_DIV;
              cnt   <= CW'(DW);
            end
          end
        end
        S_DIV: begin
          rem_r <= rem_next_c;
          q_r   <= q_next_c;
          cnt   <= cnt - CW'(1);
          // Results are published only on the final step, so they hold through the next op.
          if (cnt == CW'(1)) begin
            state       <= S_DONE;
            quotient_r  <= q_next_c;
            remainder_r <= rem_next_c;
            dz_r        <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.dz        = dz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake corner
// sequences, and random back-to-back operations against an arithmetic model.
module tb_seq_divider;

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 8;

  logic clk;
  logic rst_n;

  seq_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_divider #(.DW(DW), .VW(VW), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          done_at;   // index of the first done cycle after the start edge
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op on the next negedge, then watch until done (bounded).
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r, output logic z,
                        output int done_at, output int busy_cnt);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    done_at  = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = i;
        break;
      end
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.dz;
  endtask

  vec_t        vecs[$];
  logic [15:0] q, ra;
  logic [7:0]  r, rb;
  logic        z;
  int          done_at, busy_cnt, done_seen;
  logic [15:0] mq;
  logic [7:0]  mr;
  logic        mz;

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;

    // DW+1: done appears in the cycle after edge T16; divide-by-zero in the cycle after T0.
    vecs.push_back('{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 17});
    vecs.push_back('{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17});
    vecs.push_back('{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17});
    vecs.push_back('{16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 17});
    vecs.push_back('{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 17});
    vecs.push_back('{16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1});
    vecs.push_back('{16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 17});

    repeat (3) @(negedge clk);
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_done",      32'(bus.done),      32'd0);
    check("reset_quotient",  32'(bus.quotient),  32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_dz",        32'(bus.dz),        32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, q, r, z, done_at, busy_cnt);
      check($sformatf("vec%0d_done_at", k),  32'(done_at), 32'(vecs[k].done_at));
      check($sformatf("vec%0d_busy_cnt", k), 32'(busy_cnt), 32'(vecs[k].done_at));
      check($sformatf("vec%0d_quotient", k), 32'(q), 32'(vecs[k].q));
      check($sformatf("vec%0d_remainder", k), 32'(r), 32'(vecs[k].r));
      check($sformatf("vec%0d_dz", k), 32'(z), 32'(vecs[k].z));
    end

    // start re-asserted with other operands through DIV and DONE must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'h03E8; bus.divisor = 8'h07;
    @(posedge clk);
    @(negedge clk);
    bus.dividend = 16'h1234; bus.divisor = 8'h05;
    done_seen = 0;
    for (int i = 1; i <= 17; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("ignore_done_cycle17", 32'(bus.done), 32'd1);
    check("ignore_quotient",  32'(bus.quotient),  32'h008E);
    check("ignore_remainder", 32'(bus.remainder), 32'h06);
    @(negedge clk);
    check("ignore_done_one_cycle", 32'(bus.done), 32'd0);
    check("ignore_idle_after_done", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("ignore_single_done", 32'(done_seen), 32'd1);
    check("ignore_still_idle", 32'(bus.busy), 32'd0);
    check("ignore_result_held", 32'(bus.quotient), 32'h008E);

    // reset part-way through an operation
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'hABCD; bus.divisor = 8'h13;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("midreset_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_busy",      32'(bus.busy),      32'd0);
    check("midreset_quotient",  32'(bus.quotient),  32'd0);
    check("midreset_remainder", 32'(bus.remainder), 32'd0);
    check("midreset_dz",        32'(bus.dz),        32'd0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      if (rst_n == 1'b0) rst_n = 1'b1;
    end
    check("midreset_no_done", 32'(done_seen), 32'd0);
    // 43981 = 2314*19 + 15
    run_op(16'hABCD, 8'h13, q, r, z, done_at, busy_cnt);
    check("after_reset_done_at",   32'(done_at), 32'd17);
    check("after_reset_quotient",  32'(q), 32'h090A);
    check("after_reset_remainder", 32'(r), 32'h0F);
    check("after_reset_dz",        32'(z), 32'd0);

    // random back-to-back operations against plain arithmetic
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 8'd0;
        1:       rb = 8'd1;
        2:       rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      if (n % 7 == 0) ra = 16'($urandom_range(0, 300));
      if (rb == 8'd0) begin
        mq = 16'hFFFF; mr = 8'h00; mz = 1'b1;
      end else begin
        mq = ra / 16'(rb); mr = 8'(ra % 16'(rb)); mz = 1'b0;
      end
      run_op(ra, rb, q, r, z, done_at, busy_cnt);
      check($sformatf("rnd%0d_done_at a=%h b=%h", n, ra, rb), 32'(done_at), (rb == 8'd0) ? 32'd1 : 32'd17);
      check($sformatf("rnd%0d_quotient a=%h b=%h", n, ra, rb), 32'(q), 32'(mq));
      check($sformatf("rnd%0d_remainder a=%h b=%h", n, ra, rb), 32'(r), 32'(mr));
      check($sformatf("rnd%0d_dz a=%h b=%h", n, ra, rb), 32'(z), 32'(mz));
      if (rb != 8'd0 && q < 16'd256)
        check($sformatf("rnd%0d_identity a=%h b=%h", n, ra, rb),
              32'(q) * 32'(rb) + 32'(r), 32'(ra));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
